// File: rtl/clock_pkg.sv
// clock_pkg: shared FSM state type, BCD digit type, time limits and BCD helpers for the alarm clock.
package clock_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE_WAIT} fsm_state_t;
  typedef logic [3:0] digit_t;
  localparam logic [7:0] MAX_HOUR = 8'h23;
  localparam logic [7:0] MAX_MIN = 8'h59;
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
  endfunction
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/alarm_clock_core_if.sv
// alarm_clock_core_if: time/alarm programming and snooze/dismiss inputs, display digits and alarm outputs.
interface alarm_clock_core_if #(parameter int NUM_ALARMS = 4);
  localparam int IW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
  logic SET_LOAD;
  logic [7:0] SET_HOUR, SET_MIN;
  logic ALM_WR;
  logic [IW-1:0] ALM_IDX;
  logic [7:0] ALM_HOUR, ALM_MIN;
  logic [NUM_ALARMS-1:0] ALM_ENA;
  logic SNOOZE, DISMISS;
  clock_pkg::digit_t HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE;
  logic SEC_TICK;
  logic [NUM_ALARMS-1:0] ALARM_HIT;
  logic RINGING, BUZZER;
  modport master (
    output SET_LOAD, SET_HOUR, SET_MIN, ALM_WR, ALM_IDX, ALM_HOUR, ALM_MIN, ALM_ENA, SNOOZE, DISMISS,
    input HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE, SEC_TICK, ALARM_HIT, RINGING, BUZZER
  );
  modport slave (
    input SET_LOAD, SET_HOUR, SET_MIN, ALM_WR, ALM_IDX, ALM_HOUR, ALM_MIN, ALM_ENA, SNOOZE, DISMISS,
    output HOUR_TEN, HOUR_ONE, MIN_TEN, MIN_ONE, SEC_TEN, SEC_ONE, SEC_TICK, ALARM_HIT, RINGING, BUZZER
  );
endinterface

// File: rtl/alarm_clock_core_bcd_time_counter.sv
// bcd_time_counter: one-second prescaler and BCD HH:MM:SS chain with synchronous time load.
// With ALARM_TONE_EN it also reports whether the prescaler is in the first half of the second.
module bcd_time_counter import clock_pkg::*; #(
  parameter int CLK_HZ = 50000000
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [7:0] set_hour,
  input logic [7:0] set_min,
`ifdef ALARM_TONE_EN
  output logic first_half,
`endif
  output logic tick,
  output logic new_min,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [PW-1:0] presc;
  logic load_ok, sec_wrap, min_wrap;
  assign load_ok = load && bcd_valid(set_hour, MAX_HOUR) && bcd_valid(set_min, MAX_MIN);
  assign tick = presc == PW'(CLK_HZ - 1);
  assign sec_wrap = sec == MAX_MIN;
  assign min_wrap = min == MAX_MIN;
`ifdef ALARM_TONE_EN
  assign first_half = presc < PW'(CLK_HZ / 2);
`endif
  // new_min marks the cycle in which the time register first shows HH:MM:00
  always_ff @(posedge clk)
    if (rst) begin
      presc <= '0;
      hour <= '0;
      min <= '0;
      sec <= '0;
      new_min <= 1'b0;
    end else begin
      new_min <= load_ok || (tick && sec_wrap);
      presc <= load_ok || tick ? '0 : presc + PW'(1);
      if (load_ok) begin
        hour <= set_hour;
        min <= set_min;
        sec <= '0;
      end else if (tick) begin
        sec <= sec_wrap ? '0 : bcd_inc(sec);
        if (sec_wrap) min <= min_wrap ? '0 : bcd_inc(min);
        if (sec_wrap && min_wrap) hour <= hour == MAX_HOUR ? '0 : bcd_inc(hour);
      end
    end
endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: BCD timekeeper with NUM_ALARMS programmable alarms, snooze/dismiss and a timed buzzer.
// Define ALARM_TONE_EN for a gated ~1 kHz buzzer tone instead of a steady level.
module alarm_clock_core import clock_pkg::*; #(
  parameter int CLK_HZ = 50000000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS = 60,
  parameter int SNOOZE_MIN = 5
) (
  input logic MAX10_CLK1_50,
  input logic RESET,
  alarm_clock_core_if.slave bus
);
  localparam int SNOOZE_SECS = SNOOZE_MIN * 60;
  localparam int CW = $clog2((RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS) + 1);
  localparam int IW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
  logic tick, new_min, ringing;
  logic [7:0] hh, mm, ss;
  logic [7:0] alm_hour [NUM_ALARMS];
  logic [7:0] alm_min [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match, hit, hit_n;
  logic [CW-1:0] cnt, cnt_n;
  fsm_state_t state, state_n;
`ifdef ALARM_TONE_EN
  logic first_half;
`endif
  bcd_time_counter #(.CLK_HZ(CLK_HZ)) u_time (
    .clk(MAX10_CLK1_50),
    .rst(RESET),
    .load(bus.SET_LOAD),
    .set_hour(bus.SET_HOUR),
    .set_min(bus.SET_MIN),
`ifdef ALARM_TONE_EN
    .first_half(first_half),
`endif
    .tick(tick),
    .new_min(new_min),
    .hour(hh),
    .min(mm),
    .sec(ss)
  );
  // out-of-range indices match no register and are dropped
  always_ff @(posedge MAX10_CLK1_50)
    if (RESET) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hour[i] <= '0;
        alm_min[i] <= '0;
      end
    end else if (bus.ALM_WR && bcd_valid(bus.ALM_HOUR, MAX_HOUR) && bcd_valid(bus.ALM_MIN, MAX_MIN)) begin
      for (int i = 0; i < NUM_ALARMS; i++)
        if (bus.ALM_IDX == IW'(i)) begin
          alm_hour[i] <= bus.ALM_HOUR;
          alm_min[i] <= bus.ALM_MIN;
        end
    end
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_match
    assign match[i] = new_min && bus.ALM_ENA[i] && alm_hour[i] == hh && alm_min[i] == mm;
  end
  always_ff @(posedge MAX10_CLK1_50)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      hit <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hit <= hit_n;
    end
  // cnt counts seconds rung in RINGING and seconds waited in SNOOZE_WAIT
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hit_n = hit;
    case (state)
      IDLE:
        if (|match) begin
          state_n = RINGING;
          cnt_n = '0;
          hit_n = match;
        end
      RINGING:
        if (bus.DISMISS) begin
          state_n = IDLE;
          hit_n = '0;
        end else if (bus.SNOOZE) begin
          state_n = SNOOZE_WAIT;
          cnt_n = '0;
          hit_n = hit | match;
        end else if (tick && cnt == CW'(RING_SECS - 1)) begin
          state_n = IDLE;
          hit_n = '0;
        end else begin
          hit_n = hit | match;
          cnt_n = tick ? cnt + CW'(1) : cnt;
        end
      SNOOZE_WAIT:
        if (bus.DISMISS) begin
          state_n = IDLE;
          hit_n = '0;
        end else if (|match || (tick && cnt == CW'(SNOOZE_SECS - 1))) begin
          state_n = RINGING;
          cnt_n = '0;
          hit_n = hit | match;
        end else
          cnt_n = tick ? cnt + CW'(1) : cnt;
      default: begin
        state_n = IDLE;
        hit_n = '0;
      end
    endcase
  end
  assign ringing = state == RINGING;
  assign bus.HOUR_TEN = hh[7:4];
  assign bus.HOUR_ONE = hh[3:0];
  assign bus.MIN_TEN = mm[7:4];
  assign bus.MIN_ONE = mm[3:0];
  assign bus.SEC_TEN = ss[7:4];
  assign bus.SEC_ONE = ss[3:0];
  assign bus.SEC_TICK = tick;
  assign bus.ALARM_HIT = hit;
  assign bus.RINGING = ringing;
`ifdef ALARM_TONE_EN
  localparam int TONE_DIV = CLK_HZ / 2000 > 1 ? CLK_HZ / 2000 : 1;
  localparam int TW = $clog2(TONE_DIV + 1);
  logic [TW-1:0] tone_cnt;
  logic tone;
  always_ff @(posedge MAX10_CLK1_50)
    if (RESET || !ringing) begin
      tone_cnt <= '0;
      tone <= 1'b0;
    end else if (tone_cnt == TW'(TONE_DIV - 1)) begin
      tone_cnt <= '0;
      tone <= ~tone;
    end else
      tone_cnt <= tone_cnt + TW'(1);
  assign bus.BUZZER = ringing && tone && first_half;
`else
  assign bus.BUZZER = ringing;
`endif
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed and randomized checks of alarm_clock_core against a seconds-of-day model.
module tb_alarm_clock_core;
  localparam int CLK_HZ = 4, NA = 4, RING = 3, SNZ = 1;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  alarm_clock_core_if #(.NUM_ALARMS(NA)) bus();
  alarm_clock_core #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .RING_SECS(RING), .SNOOZE_MIN(SNZ)) dut (
    .MAX10_CLK1_50(clk),
    .RESET(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int m_tod = 0, m_p = 0, m_secs = 0, m_mode = M_IDLE;
  int m_alm [NA];
  bit m_fresh = 1'b0, t;
  logic [NA-1:0] m_hit = '0, fire;
  logic [7:0] hs [4] = '{8'h08, 8'h09, 8'h24, 8'h1A};
  logic [7:0] ms [4] = '{8'h00, 8'h01, 8'h59, 8'h6A};
  function automatic int bv(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic bit bok(input logic [7:0] b, input int mx);
    return int'(b[7:4]) <= 9 && int'(b[3:0]) <= 9 && bv(b) <= mx;
  endfunction
  function automatic logic [23:0] exp_time();
    int h, m, s;
    h = m_tod / 3600;
    m = (m_tod / 60) % 60;
    s = m_tod % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [23:0] dut_time();
    return {bus.HOUR_TEN, bus.HOUR_ONE, bus.MIN_TEN, bus.MIN_ONE, bus.SEC_TEN, bus.SEC_ONE};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // model: time as seconds of day, alarms as minutes of day, rings counted in whole seconds
  always @(posedge clk) begin
    if (rst) begin
      m_tod = 0;
      m_p = 0;
      m_fresh = 1'b0;
      m_mode = M_IDLE;
      m_hit = '0;
      m_secs = 0;
      foreach (m_alm[i]) m_alm[i] = 0;
    end else begin
      t = m_p == CLK_HZ - 1;
      fire = '0;
      for (int i = 0; i < NA; i++)
        if (m_fresh && bus.ALM_ENA[i] && m_alm[i] == m_tod / 60) fire[i] = 1'b1;
      if (m_mode == M_IDLE) begin
        if (fire != 0) begin
          m_mode = M_RING;
          m_secs = 0;
          m_hit = fire;
        end
      end else if (bus.DISMISS) begin
        m_mode = M_IDLE;
        m_hit = '0;
      end else if (m_mode == M_RING) begin
        if (bus.SNOOZE) begin
          m_mode = M_SNZ;
          m_secs = 0;
          m_hit |= fire;
        end else begin
          m_secs += int'(t);
          if (m_secs == RING) begin
            m_mode = M_IDLE;
            m_hit = '0;
          end else m_hit |= fire;
        end
      end else begin
        m_secs += int'(t);
        m_hit |= fire;
        if (fire != 0 || m_secs == SNZ * 60) begin
          m_mode = M_RING;
          m_secs = 0;
        end
      end
      if (bus.ALM_WR && bok(bus.ALM_HOUR, 23) && bok(bus.ALM_MIN, 59))
        m_alm[bus.ALM_IDX] = bv(bus.ALM_HOUR) * 60 + bv(bus.ALM_MIN);
      if (bus.SET_LOAD && bok(bus.SET_HOUR, 23) && bok(bus.SET_MIN, 59)) begin
        m_tod = (bv(bus.SET_HOUR) * 60 + bv(bus.SET_MIN)) * 60;
        m_p = 0;
        m_fresh = 1'b1;
      end else begin
        if (t) m_tod = (m_tod + 1) % 86400;
        m_fresh = t && m_tod % 60 == 0;
        m_p = t ? 0 : m_p + 1;
      end
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      chk("time", 32'(dut_time()), 32'(exp_time()));
      chk("sec_tick", 32'(bus.SEC_TICK), 32'(m_p == CLK_HZ - 1));
      chk("alarm_hit", 32'(bus.ALARM_HIT), 32'(m_hit));
      chk("ringing", 32'(bus.RINGING), 32'(m_mode == M_RING));
      chk("buzzer", 32'(bus.BUZZER), 32'(m_mode == M_RING));
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_time(input logic [7:0] h, input logic [7:0] m);
    bus.SET_HOUR = h;
    bus.SET_MIN = m;
    bus.SET_LOAD = 1'b1;
    cyc(1);
    bus.SET_LOAD = 1'b0;
  endtask
  task automatic alm_write(input int idx, input logic [7:0] h, input logic [7:0] m);
    bus.ALM_IDX = 2'(idx);
    bus.ALM_HOUR = h;
    bus.ALM_MIN = m;
    bus.ALM_WR = 1'b1;
    cyc(1);
    bus.ALM_WR = 1'b0;
  endtask
  task automatic press(input bit s, input bit d);
    bus.SNOOZE = s;
    bus.DISMISS = d;
    cyc(1);
    bus.SNOOZE = 1'b0;
    bus.DISMISS = 1'b0;
  endtask
  initial begin
    {bus.SET_LOAD, bus.ALM_WR, bus.SNOOZE, bus.DISMISS} = '0;
    {bus.SET_HOUR, bus.SET_MIN, bus.ALM_HOUR, bus.ALM_MIN} = '0;
    bus.ALM_IDX = '0;
    bus.ALM_ENA = '0;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_time", 32'(dut_time()), 32'h0);
    chk("rst_ringing", 32'(bus.RINGING), 32'h0);
    chk("rst_hit", 32'(bus.ALARM_HIT), 32'h0);
    chk("rst_tick", 32'(bus.SEC_TICK), 32'h0);
    cyc(16);
    chk("four_secs", 32'(dut_time()), 32'h000004);
    set_time(8'h23, 8'h59);
    cyc(240);
    chk("midnight", 32'(dut_time()), 32'h000000);
    set_time(8'h24, 8'h00);
    set_time(8'h12, 8'h5A);
    set_time(8'h1A, 8'h00);
    chk("bad_load", 32'(dut_time()), 32'h000000);
    alm_write(0, 8'h06, 8'h30);
    bus.ALM_ENA = 4'b0001;
    set_time(8'h06, 8'h29);
    cyc(240);
    chk("pre_ring", 32'(bus.RINGING), 32'h0);
    cyc(1);
    chk("ring0", 32'(bus.RINGING), 32'h1);
    chk("hit0", 32'(bus.ALARM_HIT), 32'h1);
    cyc(11);
    chk("auto_idle", 32'(bus.RINGING), 32'h0);
    chk("auto_time", 32'(dut_time()), 32'h063003);
    chk("auto_hit", 32'(bus.ALARM_HIT), 32'h0);
    alm_write(1, 8'h07, 8'h00);
    alm_write(2, 8'h07, 8'h00);
    bus.ALM_ENA = 4'b0011;
    set_time(8'h07, 8'h00);
    cyc(1);
    chk("hit1", 32'(bus.ALARM_HIT), 32'h2);
    press(1'b0, 1'b1);
    chk("dismiss", 32'(bus.RINGING), 32'h0);
    bus.ALM_ENA = 4'b0111;
    set_time(8'h07, 8'h00);
    cyc(1);
    chk("hit12", 32'(bus.ALARM_HIT), 32'h6);
    chk("ring12", 32'(bus.RINGING), 32'h1);
    press(1'b1, 1'b0);
    chk("snooze_buzz", 32'(bus.BUZZER), 32'h0);
    chk("snooze_hit", 32'(bus.ALARM_HIT), 32'h6);
    cyc(237);
    chk("snooze_wait", 32'(bus.RINGING), 32'h0);
    cyc(1);
    chk("rering", 32'(bus.RINGING), 32'h1);
    press(1'b1, 1'b1);
    chk("both_idle", 32'(bus.RINGING), 32'h0);
    chk("both_hit", 32'(bus.ALARM_HIT), 32'h0);
    set_time(8'h07, 8'h00);
    cyc(1);
    chk("pre_rst_ring", 32'(bus.RINGING), 32'h1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_time", 32'(dut_time()), 32'h0);
    chk("midrst_ring", 32'(bus.RINGING), 32'h0);
    chk("midrst_buzz", 32'(bus.BUZZER), 32'h0);
    chk("midrst_hit", 32'(bus.ALARM_HIT), 32'h0);
    set_time(8'h00, 8'h00);
    cyc(1);
    chk("regs_cleared", 32'(bus.ALARM_HIT), 32'h7);
    press(1'b0, 1'b1);
    alm_write(3, 8'h25, 8'h00);
    alm_write(3, 8'h10, 8'h6A);
    bus.ALM_ENA = 4'b1000;
    set_time(8'h00, 8'h00);
    cyc(1);
    chk("bad_alm_wr", 32'(bus.ALARM_HIT), 32'h8);
    press(1'b0, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 799) == 0;
      bus.SET_LOAD = $urandom_range(0, 39) == 0;
      bus.SET_HOUR = hs[$urandom_range(0, 3)];
      bus.SET_MIN = ms[$urandom_range(0, 3)];
      bus.ALM_WR = $urandom_range(0, 29) == 0;
      bus.ALM_IDX = 2'($urandom);
      bus.ALM_HOUR = hs[$urandom_range(0, 3)];
      bus.ALM_MIN = ms[$urandom_range(0, 3)];
      if ($urandom_range(0, 49) == 0) bus.ALM_ENA = 4'($urandom);
      bus.SNOOZE = $urandom_range(0, 29) == 0;
      bus.DISMISS = $urandom_range(0, 59) == 0;
      cyc(1);
    end
    rst = 1'b0;
    {bus.SET_LOAD, bus.ALM_WR, bus.SNOOZE, bus.DISMISS} = '0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
